// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared datapath widths and memory-stage FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Memory-stage access sequencer states; encodings are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_reg
//  Description : MEM/WB pipeline register with load and bubble controls.
//                A bubble clears the writeback control bits so no register
//                write happens; it takes priority over load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [REG_W-1:0]  rd_o
);

    // Boundary register: bubble squashes control, load captures all fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            alu_out_o    <= '0;
            read_data_o  <= '0;
            rd_o         <= '0;
        end else if (bubble_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
        end else if (load_i) begin
            reg_write_o  <= reg_write_i;
            mem_to_reg_o <= mem_to_reg_i;
            alu_out_o    <= alu_out_i;
            read_data_o  <= read_data_i;
            rd_o         <= rd_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Sequences a data-memory load/store
//                over a req/ack handshake, stalls the pipe while the access
//                is outstanding, aborts after TIMEOUT cycles without ack and
//                registers the MEM/WB boundary for writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_W   = cpu_pkg::REG_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic [DATA_W-1:0] ALUOut_i,
    input  logic [DATA_W-1:0] mux7_i,
    input  logic [REG_W-1:0]  mux8_i,
    input  logic              dmem_ack_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [DATA_W-1:0] ALUOut_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [REG_W-1:0]  RegRD_o
);

    import cpu_pkg::*;

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT - 1);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rdata;

    logic              w_start;
    logic              w_ack;
    logic              w_tmo;
    logic              w_wb_load;
    logic              w_wb_bubble;
    logic              w_wb_reg_write;
    logic              w_wb_mem_to_reg;
    logic [DATA_W-1:0] w_wb_alu_out;
    logic [DATA_W-1:0] w_wb_read_data;
    logic [REG_W-1:0]  w_wb_rd;

    // An ack that arrives together with the last allowed cycle wins over the timeout.
    assign w_start = (r_state == ST_IDLE) && (MemRead_i || MemWrite_i);
    assign w_ack   = (r_state == ST_ACCESS) && dmem_ack_i;
    assign w_tmo   = (r_state == ST_ACCESS) && !dmem_ack_i && (r_cnt == C_CNT_MAX);

    assign dmem_req_o = (r_state == ST_ACCESS);
    assign stall_o    = w_start || (r_state == ST_ACCESS);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and MEM/WB steering; defaults pass the EX/MEM fields through.
    always_comb begin
        w_next          = r_state;
        w_wb_load       = 1'b0;
        w_wb_bubble     = 1'b0;
        w_wb_reg_write  = RegWrite_i;
        w_wb_mem_to_reg = MemToReg_i;
        w_wb_alu_out    = ALUOut_i;
        w_wb_read_data  = '0;
        w_wb_rd         = mux8_i;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_wb_bubble = 1'b1;
                    w_next      = ST_ACCESS;
                end else begin
                    w_wb_load   = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_wb_bubble = 1'b1;
                if (w_ack || w_tmo) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_wb_load       = 1'b1;
                w_wb_reg_write  = r_reg_write;
                w_wb_mem_to_reg = r_mem_to_reg;
                w_wb_alu_out    = dmem_addr_o;
                w_wb_read_data  = r_rdata;
                w_wb_rd         = r_rd;
                w_next          = ST_IDLE;
            end
            default: begin
                w_wb_bubble = 1'b1;
                w_next      = ST_IDLE;
            end
        endcase
    end

    // Request latch: address, store data, direction and WB control held for the whole access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_we_o    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_rd         <= '0;
        end else if (w_start) begin
            dmem_addr_o  <= ALUOut_i;
            dmem_wdata_o <= mux7_i;
            dmem_we_o    <= MemWrite_i;
            r_reg_write  <= RegWrite_i;
            r_mem_to_reg <= MemToReg_i;
            r_rd         <= mux8_i;
        end
    end

    // Access-cycle counter: cleared on entry, saturates at its maximum instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                           r_cnt <= '0;
        else if (w_start)                                    r_cnt <= '0;
        else if ((r_state == ST_ACCESS) && (r_cnt != C_CNT_MAX)) r_cnt <= r_cnt + 1'b1;
    end

    // Captured read data; stores and aborted accesses return zero.
    always_ff @(posedge clk_i) begin
        if (rst_i)      r_rdata <= '0;
        else if (w_ack) r_rdata <= dmem_we_o ? '0 : dmem_rdata_i;
        else if (w_tmo) r_rdata <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)      err_o <= 1'b0;
        else if (w_tmo) err_o <= 1'b1;
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (w_wb_load),
        .bubble_i     (w_wb_bubble),
        .reg_write_i  (w_wb_reg_write),
        .mem_to_reg_i (w_wb_mem_to_reg),
        .alu_out_i    (w_wb_alu_out),
        .read_data_i  (w_wb_read_data),
        .rd_i         (w_wb_rd),
        .reg_write_o  (RegWrite_o),
        .mem_to_reg_o (MemToReg_o),
        .alu_out_o    (ALUOut_o),
        .read_data_o  (ReadData_o),
        .rd_o         (RegRD_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i, MemToReg_i, RegWrite_i;
    logic [31:0] ALUOut_i, mux7_i;
    logic [4:0]  mux8_i;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_req_o, dmem_we_o, stall_o, err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        RegWrite_o, MemToReg_o;
    logic [31:0] ALUOut_o, ReadData_o;
    logic [4:0]  RegRD_o;

    int n_total = 0;
    int n_bad   = 0;
    int stall_n, req_n, wb_seen;

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .MemToReg_i   (MemToReg_i),
        .RegWrite_i   (RegWrite_i),
        .ALUOut_i     (ALUOut_i),
        .mux7_i       (mux7_i),
        .mux8_i       (mux8_i),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .RegWrite_o   (RegWrite_o),
        .MemToReg_o   (MemToReg_o),
        .ALUOut_o     (ALUOut_o),
        .ReadData_o   (ReadData_o),
        .RegRD_o      (RegRD_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst);
        MemRead_i  = rd;
        MemWrite_i = wr;
        MemToReg_i = m2r;
        RegWrite_i = rw;
        ALUOut_i   = alu;
        mux7_i     = sd;
        mux8_i     = dst;
    endtask

    // Runs one memory op from its IDLE cycle to its DONE cycle (returns at DONE's negedge).
    // ack_at = index of the ACCESS cycle that gets the ack, 0 = never.
    task automatic run_op(input int ack_at, input logic [31:0] rdata,
                          output int s_n, output int r_n, output int wb_n);
        bit seen = 1'b0;
        bit done = 1'b0;
        s_n = 0; r_n = 0; wb_n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (dmem_req_o) begin
                r_n++;
                if (RegWrite_o) wb_n++;
            end
            if (stall_o) begin
                s_n++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
            if (!done) begin
                if (dmem_req_o && r_n == ack_at) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = rdata;
                end
                tick();
                dmem_ack_i   = 1'b0;
                dmem_rdata_i = '0;
            end
        end
        if (!done) chk("op_bound", 32'd0, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = '0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick(); tick();
        rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        chk("rst_req",   32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o),    32'd0);
        chk("rst_err",   32'(err_o),      32'd0);
        chk("rst_wbrw",  32'(RegWrite_o), 32'd0);
        chk("rst_alu",   ALUOut_o,        32'd0);
        tick();

        // 1: plain ALU op, one-cycle latency, no stall
        drive(0, 0, 0, 1, 32'h1234, 32'h0, 5'd7);
        @(negedge clk_i);
        chk("alu_stall", 32'(stall_o), 32'd0);
        tick();
        chk("alu_out",  ALUOut_o,         32'h1234);
        chk("alu_rd",   32'(RegRD_o),     32'd7);
        chk("alu_rw",   32'(RegWrite_o),  32'd1);
        chk("alu_m2r",  32'(MemToReg_o),  32'd0);
        chk("alu_stl2", 32'(stall_o),     32'd0);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

        // 2: load, ack on 3rd ACCESS cycle
        drive(1, 0, 1, 1, 32'h40, 32'h0, 5'd3);
        run_op(3, 32'hDEADBEEF, stall_n, req_n, wb_seen);
        chk("ld_stall_n", stall_n,           32'd4);
        chk("ld_req_n",   req_n,             32'd3);
        chk("ld_bubble",  wb_seen,           32'd0);
        chk("ld_addr",    dmem_addr_o,       32'h40);
        chk("ld_we",      32'(dmem_we_o),    32'd0);
        chk("ld_done_rq", 32'(dmem_req_o),   32'd0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("ld_data",    ReadData_o,        32'hDEADBEEF);
        chk("ld_m2r",     32'(MemToReg_o),   32'd1);
        chk("ld_rw",      32'(RegWrite_o),   32'd1);
        chk("ld_rd",      32'(RegRD_o),      32'd3);

        // 3: store, immediate ack
        drive(0, 1, 0, 0, 32'h80, 32'hCAFE, 5'd9);
        run_op(1, 32'h1111_1111, stall_n, req_n, wb_seen);
        chk("st_stall_n", stall_n,           32'd2);
        chk("st_we",      32'(dmem_we_o),    32'd1);
        chk("st_wdata",   dmem_wdata_o,      32'hCAFE);
        chk("st_addr",    dmem_addr_o,       32'h80);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("st_rw",      32'(RegWrite_o),   32'd0);
        chk("st_data",    ReadData_o,        32'd0);
        chk("st_err",     32'(err_o),        32'd0);

        // Read and write together: store wins, read data is zero
        drive(1, 1, 1, 1, 32'hC0, 32'h77, 5'd6);
        run_op(2, 32'hFFFF, stall_n, req_n, wb_seen);
        chk("rw_we",      32'(dmem_we_o),    32'd1);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("rw_data",    ReadData_o,        32'd0);

        // 4: timeout, no ack ever
        drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd8);
        run_op(0, 32'h0, stall_n, req_n, wb_seen);
        chk("to_req_n",   req_n,             32'd64);
        chk("to_stall_n", stall_n,           32'd65);
        chk("to_done_st", 32'(stall_o),      32'd0);
        chk("to_err",     32'(err_o),        32'd1);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("to_data",    ReadData_o,        32'd0);
        chk("to_err_stk", 32'(err_o),        32'd1);

        // 5: reset on 2nd ACCESS cycle, ack arrives the cycle after
        drive(1, 0, 1, 1, 32'h44, 32'h0, 5'd2);
        tick();
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rs_req_pre", 32'(dmem_req_o),   32'd1);
        tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h5555;
        @(negedge clk_i);
        chk("rs_req",     32'(dmem_req_o),   32'd0);
        chk("rs_stall",   32'(stall_o),      32'd0);
        chk("rs_err",     32'(err_o),        32'd0);
        chk("rs_wbrw",    32'(RegWrite_o),   32'd0);
        chk("rs_alu",     ALUOut_o,          32'd0);
        chk("rs_rd",      32'(RegRD_o),      32'd0);
        tick();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        @(negedge clk_i);
        chk("rs_req2",    32'(dmem_req_o),   32'd0);
        chk("rs_data",    ReadData_o,        32'd0);
        tick();

        // Ack on the very last allowed cycle counts as an ack
        drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd1);
        run_op(64, 32'hA5A5_0001, stall_n, req_n, wb_seen);
        chk("la_req_n",   req_n,             32'd64);
        chk("la_err",     32'(err_o),        32'd0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("la_data",    ReadData_o,        32'hA5A5_0001);

        // 6: back-to-back loads held by stall
        drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd4);
        run_op(1, 32'h111, stall_n, req_n, wb_seen);
        chk("bb1_stall",  stall_n,           32'd2);
        tick();
        chk("bb1_data",   ReadData_o,        32'h111);
        chk("bb1_rd",     32'(RegRD_o),      32'd4);
        drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd5);
        run_op(2, 32'h222, stall_n, req_n, wb_seen);
        chk("bb2_stall",  stall_n,           32'd3);
        chk("bb2_bubble", wb_seen,           32'd0);
        chk("bb2_addr",   dmem_addr_o,       32'h200);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        chk("bb2_data",   ReadData_o,        32'h222);
        chk("bb2_rd",     32'(RegRD_o),      32'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
